// File: rtl/game_pkg.sv
// Shared types and defaults for the game controller slice.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    OVER
  } state_t;

  localparam int unsigned SPEED_W              = 4;
  localparam int unsigned FRAMES_PER_LEVEL_DEF = 600;
  localparam int unsigned SPEED_INIT_DEF       = 2;
  localparam int unsigned SPEED_MAX_DEF        = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/game_ctrl_edge_detect.sv
// Registered single-cycle edge detector; RISE selects rising (1) or falling (0) edge.
module edge_detect #(
  parameter bit RISE = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic pulse
);

  logic d_q;
  logic seen_idle;

  // seen_idle blocks a pulse until the input has sat at its idle level after reset,
  // so a level already held through reset is never reported as an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      d_q       <= 1'b0;
      seen_idle <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      d_q       <= d;
      seen_idle <= seen_idle | (RISE ? ~d : d);
      pulse     <= seen_idle & (RISE ? (d & ~d_q) : (~d & d_q));
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing: start/restart, per-frame score base and level-based speed ramp.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_LEVEL = FRAMES_PER_LEVEL_DEF,
  parameter int unsigned SPEED_INIT       = SPEED_INIT_DEF,
  parameter int unsigned SPEED_MAX        = SPEED_MAX_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               vs,
  input  logic               px_dinosaur,
  input  logic               px_cactus,
  output logic               game_status,
  output logic               game_over,
  output logic               frame_tick,
  output logic [SPEED_W-1:0] speed,
  output logic [15:0]        frame_count
);

  localparam logic [15:0]        LEVEL_LAST = 16'(FRAMES_PER_LEVEL - 1);
  localparam logic [SPEED_W-1:0] SPD_INIT   = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(SPEED_MAX);

  state_t      state_q;
  state_t      state_d;
  logic        start_pulse;
  logic        collision;
  logic [15:0] level_q;

  edge_detect #(.RISE(1'b1)) u_start_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (START),
    .pulse (start_pulse)
  );

  edge_detect #(.RISE(1'b0)) u_vs_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (vs),
    .pulse (frame_tick)
  );

  // The collision is captured directly by the state register, giving OVER one cycle after the pixel.
  assign collision = px_dinosaur & px_cactus;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_pulse) state_d = ARMED;
      ARMED:   if (frame_tick)  state_d = RUN;
      RUN:     if (collision)   state_d = OVER;
      OVER:    if (start_pulse) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      game_status <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      game_status <= (state_d == RUN);
      game_over   <= (state_d == OVER);
    end
  end

  // Score base, level counter and speed ramp; a collision on a tick suppresses the increment.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_count <= '0;
      level_q     <= '0;
      speed       <= SPD_INIT;
    end else if (state_q == ARMED && frame_tick) begin
      frame_count <= '0;
      level_q     <= '0;
      speed       <= SPD_INIT;
    end else if (state_q == RUN && frame_tick && !collision) begin
      frame_count <= sat_inc16(frame_count);
      if (level_q == LEVEL_LAST) begin
        level_q <= '0;
        if (speed < SPD_MAX) speed <= speed + 1'b1;
      end else begin
        level_q <= level_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with hand-computed expectations.
module tb_game_ctrl;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        vs;
  logic        px_dinosaur;
  logic        px_cactus;
  logic        game_status;
  logic        game_over;
  logic        frame_tick;
  logic [3:0]  speed;
  logic [15:0] frame_count;

  int unsigned vecs;
  int unsigned errs;

  game_ctrl #(
    .FRAMES_PER_LEVEL (600),
    .SPEED_INIT       (2),
    .SPEED_MAX        (8)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .vs          (vs),
    .px_dinosaur (px_dinosaur),
    .px_cactus   (px_cactus),
    .game_status (game_status),
    .game_over   (game_over),
    .frame_tick  (frame_tick),
    .speed       (speed),
    .frame_count (frame_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One video frame: vs low for one cycle, back high; returns once the tick has been consumed.
  task automatic frame();
    vs = 1'b0;
    @(negedge CLK);
    vs = 1'b1;
    @(negedge CLK);
  endtask

  // Press and release START; the FSM has reacted when this returns.
  task automatic press_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL rst_status got=%0b exp=0", game_status); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL rst_over got=%0b exp=0", game_over); end
    vecs++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL rst_tick got=%0b exp=0", frame_tick); end
    vecs++; if (speed !== 4'd2) begin errs++; $display("FAIL rst_speed got=%0d exp=2", speed); end
    vecs++; if (frame_count !== 16'd0) begin errs++; $display("FAIL rst_count got=%0d exp=0", frame_count); end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_start();
    press_start();
    repeat (3) @(negedge CLK);
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL armed_status got=%0b exp=0", game_status); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL armed_over got=%0b exp=0", game_over); end
    vs = 1'b0;
    @(negedge CLK);
    vecs++; if (frame_tick !== 1'b1) begin errs++; $display("FAIL tick_pulse got=%0b exp=1", frame_tick); end
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL tick_cycle_status got=%0b exp=0", game_status); end
    vs = 1'b1;
    @(negedge CLK);
    vecs++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL tick_single got=%0b exp=0", frame_tick); end
    vecs++; if (game_status !== 1'b1) begin errs++; $display("FAIL run_status got=%0b exp=1", game_status); end
    vecs++; if (speed !== 4'd2) begin errs++; $display("FAIL run_speed got=%0d exp=2", speed); end
    vecs++; if (frame_count !== 16'd0) begin errs++; $display("FAIL run_count got=%0d exp=0", frame_count); end
  endtask

  task automatic test_level();
    repeat (599) frame();
    vecs++; if (speed !== 4'd2) begin errs++; $display("FAIL lvl_599_speed got=%0d exp=2", speed); end
    vecs++; if (frame_count !== 16'd599) begin errs++; $display("FAIL lvl_599_count got=%0d exp=599", frame_count); end
    frame();
    vecs++; if (speed !== 4'd3) begin errs++; $display("FAIL lvl_600_speed got=%0d exp=3", speed); end
    vecs++; if (frame_count !== 16'd600) begin errs++; $display("FAIL lvl_600_count got=%0d exp=600", frame_count); end
    press_start();
    @(negedge CLK);
    vecs++; if (game_status !== 1'b1) begin errs++; $display("FAIL start_in_run got=%0b exp=1", game_status); end
    repeat (3600) frame();
    vecs++; if (speed !== 4'd8) begin errs++; $display("FAIL lvl_max_speed got=%0d exp=8", speed); end
    vecs++; if (frame_count !== 16'd4200) begin errs++; $display("FAIL lvl_max_count got=%0d exp=4200", frame_count); end
    repeat (600) frame();
    vecs++; if (speed !== 4'd8) begin errs++; $display("FAIL lvl_sat_speed got=%0d exp=8", speed); end
    vecs++; if (frame_count !== 16'd4800) begin errs++; $display("FAIL lvl_sat_count got=%0d exp=4800", frame_count); end
  endtask

  task automatic test_collision();
    vs = 1'b0;
    @(negedge CLK);
    px_dinosaur = 1'b1;
    px_cactus   = 1'b1;
    vs = 1'b1;
    @(negedge CLK);
    px_dinosaur = 1'b0;
    px_cactus   = 1'b0;
    vecs++; if (game_over !== 1'b1) begin errs++; $display("FAIL coll_over got=%0b exp=1", game_over); end
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL coll_status got=%0b exp=0", game_status); end
    vecs++; if (frame_count !== 16'd4800) begin errs++; $display("FAIL coll_count got=%0d exp=4800", frame_count); end
    px_dinosaur = 1'b1;
    px_cactus   = 1'b1;
    frame();
    px_dinosaur = 1'b0;
    px_cactus   = 1'b0;
    vecs++; if (game_over !== 1'b1) begin errs++; $display("FAIL over_hold got=%0b exp=1", game_over); end
    vecs++; if (frame_count !== 16'd4800) begin errs++; $display("FAIL over_count got=%0d exp=4800", frame_count); end
    vecs++; if (speed !== 4'd8) begin errs++; $display("FAIL over_speed got=%0d exp=8", speed); end
  endtask

  task automatic test_restart();
    START = 1'b1;
    repeat (2) @(negedge CLK);
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL restart_over got=%0b exp=0", game_over); end
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL restart_armed got=%0b exp=0", game_status); end
    frame();
    vecs++; if (game_status !== 1'b1) begin errs++; $display("FAIL restart_run got=%0b exp=1", game_status); end
    vecs++; if (frame_count !== 16'd0) begin errs++; $display("FAIL restart_count got=%0d exp=0", frame_count); end
    vecs++; if (speed !== 4'd2) begin errs++; $display("FAIL restart_speed got=%0d exp=2", speed); end
    frame();
    frame();
    vecs++; if (frame_count !== 16'd2) begin errs++; $display("FAIL restart_hold_count got=%0d exp=2", frame_count); end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    repeat (1798) frame();
    vecs++; if (speed !== 4'd5) begin errs++; $display("FAIL pre_rst_speed got=%0d exp=5", speed); end
    vecs++; if (frame_count !== 16'd1800) begin errs++; $display("FAIL pre_rst_count got=%0d exp=1800", frame_count); end
    START = 1'b1;
    vs = 1'b0;
    px_dinosaur = 1'b1;
    px_cactus = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL midrst_status got=%0b exp=0", game_status); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL midrst_over got=%0b exp=0", game_over); end
    vecs++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL midrst_tick got=%0b exp=0", frame_tick); end
    vecs++; if (speed !== 4'd2) begin errs++; $display("FAIL midrst_speed got=%0d exp=2", speed); end
    vecs++; if (frame_count !== 16'd0) begin errs++; $display("FAIL midrst_count got=%0d exp=0", frame_count); end
    RESET = 1'b0;
    vs = 1'b1;
    px_dinosaur = 1'b0;
    px_cactus = 1'b0;
    repeat (3) @(negedge CLK);
    frame();
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL held_start got=%0b exp=0", game_status); end
    START = 1'b0;
    @(negedge CLK);
    press_start();
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    frame();
    vecs++; if (game_status !== 1'b0) begin errs++; $display("FAIL armed_rst got=%0b exp=0", game_status); end
    press_start();
    frame();
    vecs++; if (game_status !== 1'b1) begin errs++; $display("FAIL rerun_status got=%0b exp=1", game_status); end
  endtask

  task automatic test_saturate();
    force dut.frame_count = 16'hFFFE;
    @(negedge CLK);
    release dut.frame_count;
    @(negedge CLK);
    frame();
    vecs++; if (frame_count !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got=%0h exp=ffff", frame_count); end
    frame();
    vecs++; if (frame_count !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got=%0h exp=ffff", frame_count); end
    vecs++; if (game_status !== 1'b1) begin errs++; $display("FAIL sat_status got=%0b exp=1", game_status); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    RESET = 1'b1;
    START = 1'b0;
    vs = 1'b1;
    px_dinosaur = 1'b0;
    px_cactus = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset();
    test_start();
    test_level();
    test_collision();
    test_restart();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
